// File: rtl/mips_core_pkg.sv
// Shared fetch/branch types: outcome encoding, 2-bit bimodal counter and its update rule.
// Latency: n/a (types and a pure function); backpressure: n/a.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  typedef logic [1:0] BhtCounter;

  localparam BhtCounter BHT_RESET     = 2'b01;
  localparam int        BHT_TAKEN_BIT = 1;

  function automatic BhtCounter bht_next(input BhtCounter c, input logic taken);
    BhtCounter n;
    n = c;
    if (taken && c != 2'b11)
      n = c + 2'b01;
    else if (!taken && c != 2'b00)
      n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped flop BTB: combinational read returning hit/target, synchronous write, reset clears valids.
// Latency: read 0 cycles, write visible next cycle; backpressure: none, a write is always accepted.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_rd_pc,
  output logic                  o_rd_hit,
  output logic [ADDR_WIDTH-1:0] o_rd_target,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_pc,
  input  logic [ADDR_WIDTH-1:0] i_wr_target
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  logic                  r_valid  [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic                  w_unused_byte_bits;

  assign w_rd_idx = i_rd_pc[INDEX_BITS+1:2];
  assign w_rd_tag = i_rd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_wr_idx = i_wr_pc[INDEX_BITS+1:2];
  // Instruction-aligned PCs: byte offset never participates in index or tag.
  assign w_unused_byte_bits = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_target = o_rd_hit ? r_target[w_rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_valid[i] <= 1'b0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx]  <= 1'b1;
      r_tag[w_wr_idx]    <= i_wr_pc[ADDR_WIDTH-1:INDEX_BITS+2];
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/bimodal_branch_predictor.sv
// Bimodal predictor: BTB + 2-bit counter table looked up with the fetch PC, trained by resolved branches.
// Latency: prediction 0 cycles, training visible next cycle; backpressure: none, every qualified resolution is consumed.
module bimodal_branch_predictor
  import mips_core_pkg::*;
#(
  parameter int BHT_INDEX_BITS = 8,
  parameter int BTB_INDEX_BITS = 6,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_pc_current,
  output logic                  o_pred_is_branch,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  output logic                  o_pred_prediction,
  input  logic                  i_res_is_branch,
  input  logic [ADDR_WIDTH-1:0] i_res_target,
  input  logic                  i_res_prediction,
  input  logic                  i_res_outcome,
  input  logic [ADDR_WIDTH-1:0] i_res_pc,
  input  logic                  i_res_valid,
  output logic [STAT_WIDTH-1:0] o_branch_count,
  output logic [STAT_WIDTH-1:0] o_mispredict_count
);

  localparam int BHT_ENTRIES = 2 ** BHT_INDEX_BITS;

  BhtCounter               r_bht [BHT_ENTRIES];
  logic [STAT_WIDTH-1:0]   r_branch_count;
  logic [STAT_WIDTH-1:0]   r_mispredict_count;

  logic                      w_upd;
  logic                      w_btb_hit;
  logic [BHT_INDEX_BITS-1:0] w_rd_idx;
  logic [BHT_INDEX_BITS-1:0] w_wr_idx;

  assign w_upd    = i_res_valid & i_res_is_branch;
  assign w_rd_idx = i_pc_current[BHT_INDEX_BITS+1:2];
  assign w_wr_idx = i_res_pc[BHT_INDEX_BITS+1:2];

  branch_target_buffer #(
    .INDEX_BITS (BTB_INDEX_BITS)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_pc     (i_pc_current),
    .o_rd_hit    (w_btb_hit),
    .o_rd_target (o_pred_target),
    .i_wr_en     (w_upd),
    .i_wr_pc     (i_res_pc),
    .i_wr_target (i_res_target)
  );

  assign o_pred_is_branch   = w_btb_hit;
  assign o_pred_prediction  = w_btb_hit & r_bht[w_rd_idx][BHT_TAKEN_BIT];
  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        r_bht[i] <= BHT_RESET;
    end else if (w_upd) begin
      r_bht[w_wr_idx] <= bht_next(r_bht[w_wr_idx], i_res_outcome == TAKEN);
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_upd) begin
      if (r_branch_count != '1)
        r_branch_count <= r_branch_count + 1'b1;
      if ((i_res_prediction != i_res_outcome) && (r_mispredict_count != '1))
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Scoreboard bench for bimodal_branch_predictor: expected lookup/stat values queued at drive time, compared at negedge.
module tb_bimodal_branch_predictor;

  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_pc_current;
  logic          o_pred_is_branch;
  logic [31:0]   o_pred_target;
  logic          o_pred_prediction;
  logic          i_res_is_branch;
  logic [31:0]   i_res_target;
  logic          i_res_prediction;
  logic          i_res_outcome;
  logic [31:0]   i_res_pc;
  logic          i_res_valid;
  logic [SW-1:0] o_branch_count;
  logic [SW-1:0] o_mispredict_count;

  bimodal_branch_predictor #(
    .BHT_INDEX_BITS (8),
    .BTB_INDEX_BITS (6),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_pc_current       (i_pc_current),
    .o_pred_is_branch   (o_pred_is_branch),
    .o_pred_target      (o_pred_target),
    .o_pred_prediction  (o_pred_prediction),
    .i_res_is_branch    (i_res_is_branch),
    .i_res_target       (i_res_target),
    .i_res_prediction   (i_res_prediction),
    .i_res_outcome      (i_res_outcome),
    .i_res_pc           (i_res_pc),
    .i_res_valid        (i_res_valid),
    .o_branch_count     (o_branch_count),
    .o_mispredict_count (o_mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    logic        pred;
    int          bc;
    int          mc;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int          m_ctr [256];
  bit          m_bv  [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_bc;
  int          m_mc;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%h expected=%h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_train(input logic [31:0] rpc, input logic [31:0] tgt, input logic pr, input logic oc);
    int bi;
    int ti;
    bi = int'(rpc[9:2]);
    ti = int'(rpc[7:2]);
    if (oc && m_ctr[bi] < 3) m_ctr[bi]++;
    else if (!oc && m_ctr[bi] > 0) m_ctr[bi]--;
    m_bv[ti]  = 1'b1;
    m_tag[ti] = rpc[31:8];
    m_tgt[ti] = tgt;
    if (m_bc < SAT) m_bc++;
    if (pr != oc && m_mc < SAT) m_mc++;
  endtask

  // One full clock cycle: drive, queue expectation, compare at negedge, advance model at posedge.
  task automatic cyc(input logic [31:0] pc, input logic r, input logic v, input logic isb,
                     input logic [31:0] rpc, input logic [31:0] tgt, input logic pr, input logic oc);
    exp_t e;
    exp_t got;
    int   ti;
    rst = r; i_pc_current = pc; i_res_valid = v; i_res_is_branch = isb;
    i_res_pc = rpc; i_res_target = tgt; i_res_prediction = pr; i_res_outcome = oc;
    ti = int'(pc[7:2]);
    e.hit  = m_bv[ti] && (m_tag[ti] == pc[31:8]);
    e.tgt  = e.hit ? m_tgt[ti] : 32'h0;
    e.pred = e.hit && (m_ctr[int'(pc[9:2])] >= 2);
    e.bc   = m_bc;
    e.mc   = m_mc;
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    check("is_branch", {31'b0, o_pred_is_branch}, {31'b0, got.hit});
    check("target", o_pred_target, got.tgt);
    check("prediction", {31'b0, o_pred_prediction}, {31'b0, got.pred});
    check("branch_count", {28'b0, o_branch_count}, got.bc);
    check("mispredict_count", {28'b0, o_mispredict_count}, got.mc);
    @(posedge clk);
    if (r) model_reset();
    else if (v && isb) model_train(rpc, tgt, pr, oc);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic pr, input logic oc);
    cyc(pc, 1'b0, 1'b1, 1'b1, pc, tgt, pr, oc);
  endtask

  localparam logic [31:0] PC_A  = 32'h0040_0010;
  localparam logic [31:0] PC_B  = 32'h0040_0110;
  localparam logic [31:0] TGT_A = 32'h0040_0100;
  localparam logic [31:0] TGT_B = 32'h0040_0800;

  logic [31:0] pc_pool [5];

  initial begin
    pc_pool[0] = PC_A;
    pc_pool[1] = PC_B;
    pc_pool[2] = 32'h0040_0014;
    pc_pool[3] = 32'h0040_1010;
    pc_pool[4] = 32'h0040_0410;

    rst = 1'b1; i_pc_current = '0; i_res_valid = 1'b0; i_res_is_branch = 1'b0;
    i_res_pc = '0; i_res_target = '0; i_res_prediction = 1'b0; i_res_outcome = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;

    phase = "reset";
    look(PC_A);
    check("reset_is_branch", {31'b0, o_pred_is_branch}, 32'h0);

    phase = "first_train";
    train(PC_A, TGT_A, 1'b0, 1'b1);
    look(PC_A);
    check("first_target", o_pred_target, TGT_A);
    check("first_pred_taken", {31'b0, o_pred_prediction}, 32'h1);
    check("first_stats", {24'b0, o_branch_count, o_mispredict_count}, 32'h11);

    phase = "hysteresis";
    train(PC_A, TGT_A, 1'b1, 1'b1);
    train(PC_A, TGT_A, 1'b1, 1'b1);
    train(PC_A, TGT_A, 1'b1, 1'b0);
    look(PC_A);
    check("weak_taken_pred", {31'b0, o_pred_prediction}, 32'h1);
    train(PC_A, TGT_A, 1'b1, 1'b0);
    look(PC_A);
    check("weak_nt_pred", {31'b0, o_pred_prediction}, 32'h0);

    phase = "qualify";
    cyc(PC_A, 1'b0, 1'b0, 1'b1, PC_A, TGT_B, 1'b0, 1'b1);
    cyc(PC_A, 1'b0, 1'b0, 1'b1, PC_A, TGT_B, 1'b1, 1'b0);
    cyc(PC_A, 1'b0, 1'b1, 1'b0, PC_A, TGT_B, 1'b0, 1'b1);
    look(PC_A);
    check("qual_target_kept", o_pred_target, TGT_A);

    phase = "rdw";
    train(PC_A, TGT_A, 1'b0, 1'b1);
    look(PC_A);

    phase = "alias";
    train(PC_B, TGT_B, 1'b0, 1'b1);
    look(PC_A);
    check("alias_evicted", {31'b0, o_pred_is_branch}, 32'h0);
    look(PC_B);
    check("alias_hit", {31'b0, o_pred_is_branch}, 32'h1);

    phase = "rst_prio";
    cyc(PC_B, 1'b1, 1'b1, 1'b1, PC_B, TGT_A, 1'b0, 1'b1);
    look(PC_B);
    look(PC_A);
    check("rst_prio_bc", {28'b0, o_branch_count}, 32'h0);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      logic [31:0] lp;
      logic [31:0] rp;
      lp = pc_pool[$urandom_range(0, 4)];
      rp = pc_pool[$urandom_range(0, 4)];
      cyc(lp, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
          rp, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    phase = "saturate";
    cyc(PC_A, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      train(PC_A, TGT_A, 1'b0, 1'b1);
    look(PC_A);
    check("sat_branch_count", {28'b0, o_branch_count}, 32'hF);
    check("sat_mispredict_count", {28'b0, o_mispredict_count}, 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
